// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN datapath and its image loader:
//   - image geometry and pixel width
//   - binarization threshold
//   - image_t, the packed binary frame type presented on the BNN layer input
//   - loader_state_e, the two-state loader FSM encoding
//   - binarize(), the unsigned threshold compare used on every pixel
// -----------------------------------------------------------------------------
package bnn_pkg;

  localparam int IMG_H  = 28;
  localparam int IMG_W  = 28;
  localparam int PIX_W  = 8;
  localparam int THRESH = 128;

  typedef logic [0:0][IMG_H-1:0][IMG_W-1:0] image_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_e;

  // Pixel at or above the threshold is a 1; comparison is unsigned.
  function automatic logic binarize(input logic [PIX_W-1:0] pix);
    return (pix >= PIX_W'(THRESH));
  endfunction

endpackage

// File: rtl/bnn_image_loader.sv
// -----------------------------------------------------------------------------
// bnn_image_loader
// Collects a raster stream of grayscale pixels, binarizes each one and builds
// a complete IMG_H x IMG_W binary frame for the BNN layer input. One frame
// buffer: while a finished frame waits for the consumer the pixel stream is
// stalled.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   pix_i          grayscale pixel, raster order
//   pix_sof_i      first pixel of a frame (qualified by pix_valid_i)
//   pix_valid_i    pixel valid
//   pix_ready_o    loader can accept a pixel
//   image_o        binary frame; raster (r,c) sits at [0][IMG_H-1-r][IMG_W-1-c]
//   frame_valid_o  image_o holds a complete frame
//   frame_ready_i  downstream consumes the frame
//   resync_o       one-cycle pulse when a partial frame is dropped on early SOF
// -----------------------------------------------------------------------------
module bnn_image_loader
  import bnn_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_sof_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output image_t           image_o,
  output logic             frame_valid_o,
  input  logic             frame_ready_i,
  output logic             resync_o
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  loader_state_e    state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  image_t           image_q;
  logic             frame_valid_q;
  logic             pix_ready_q;
  logic             resync_q;

  logic             pix_bit;
  logic             accept;
  logic             at_start;
  logic             last_pix;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;

  // Handshake, threshold bit and mirrored buffer coordinates for the current pixel.
  always_comb begin
    pix_bit  = binarize(pix_i);
    accept   = pix_valid_i && pix_ready_q;
    at_start = (row_q == '0) && (col_q == '0);
    last_pix = (row_q == ROW_W'(IMG_H-1)) && (col_q == COL_W'(IMG_W-1));
    // Top-left pixel lands in the MSB of the MSB row, hence the mirroring.
    row_idx  = ROW_W'(IMG_H-1) - row_q;
    col_idx  = COL_W'(IMG_W-1) - col_q;
  end

  // Loader FSM: counters, frame buffer and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= LOAD;
      row_q         <= '0;
      col_q         <= '0;
      image_q       <= '0;
      frame_valid_q <= 1'b0;
      pix_ready_q   <= 1'b1;
      resync_q      <= 1'b0;
    end else begin
      resync_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (pix_sof_i && !at_start) begin
              // Early SOF: drop the partial frame, this pixel restarts at (0,0).
              // Stale bits are left in place; the new frame overwrites them all.
              image_q[0][IMG_H-1][IMG_W-1] <= pix_bit;
              row_q    <= '0;
              col_q    <= COL_W'(1);
              resync_q <= 1'b1;
            end else begin
              image_q[0][row_idx][col_idx] <= pix_bit;
              if (last_pix) begin
                row_q         <= '0;
                col_q         <= '0;
                state_q       <= FULL;
                frame_valid_q <= 1'b1;
                pix_ready_q   <= 1'b0;
              end else if (col_q == COL_W'(IMG_W-1)) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
            end
          end else begin
            state_q <= LOAD;
          end
        end
        FULL: begin
          // Ready comes back one cycle after the handshake: one bubble per frame.
          if (frame_ready_i) begin
            state_q       <= LOAD;
            frame_valid_q <= 1'b0;
            pix_ready_q   <= 1'b1;
          end else begin
            state_q <= FULL;
          end
        end
        default: begin
          state_q       <= LOAD;
          row_q         <= '0;
          col_q         <= '0;
          frame_valid_q <= 1'b0;
          pix_ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign pix_ready_o   = pix_ready_q;
  assign image_o       = image_q;
  assign frame_valid_o = frame_valid_q;
  assign resync_o      = resync_q;

endmodule

// File: doc/bnn_image_loader.md
Name: bnn_image_loader

Overview:
- Upstream feeder for the BNN top.
- Accepts a raster stream of 8-bit grayscale pixels over a valid/ready handshake and binarizes each pixel against a threshold.
- Assembles a full 28x28 binary frame and presents it to the BNN `layer_i` input with a frame-level valid/ready handshake.
- Single frame buffer; the pixel stream is stalled while a completed frame awaits consumption.

Parameters:
- IMG_H, 28, image rows
- IMG_W, 28, image columns
- PIX_W, 8, grayscale pixel width
- THRESH, 128, binarization threshold; pixel >= THRESH -> 1, else 0 (unsigned compare)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pix_i  in  PIX_W  grayscale pixel, raster order (top row first, left to right)
- pix_sof_i  in  1  marks first pixel of a frame; qualified by pix_valid_i
- pix_valid_i  in  1  pixel valid
- pix_ready_o  out  1  loader can accept a pixel
- image_o  out  1*IMG_H*IMG_W (packed [0:0][IMG_H-1:0][IMG_W-1:0])  binary frame to BNN layer_i
- frame_valid_o  out  1  image_o holds a complete frame
- frame_ready_i  in  1  downstream consumes frame
- resync_o  out  1  one-cycle pulse: partial frame discarded on early SOF

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high.
- Reset values:
  - state = LOAD
  - pixel counter = 0, row = 0, col = 0
  - image_o = all 0
  - frame_valid_o = 0, resync_o = 0
  - pix_ready_o = 1 on the first cycle after reset
- Pixel placement: pixel at raster row r, column c is stored at image_o[0][IMG_H-1-r][IMG_W-1-c]. The top-left pixel therefore lands in the MSB of the MSB row.
- Pixel accept: pix_valid_i && pix_ready_o.
- Counters: row/col counters with wrap. col increments per accept; at col == IMG_W-1, col -> 0 and row increments.
- State LOAD:
  - pix_ready_o = 1, frame_valid_o = 0.
  - Each accepted pixel writes its threshold bit into image_o at the counter position.
  - Accepting the pixel at row == IMG_H-1, col == IMG_W-1 (784th pixel) resets the counters and moves to FULL.
- State FULL:
  - pix_ready_o = 0, frame_valid_o = 1, image_o held stable.
  - When frame_ready_i = 1, return to LOAD next cycle.
  - Image bits are not cleared; every bit is overwritten by the next frame.
- Latency:
  - frame_valid_o rises the cycle after the last pixel is accepted.
  - pix_ready_o rises the cycle after the frame handshake, giving one bubble between frames.
- SOF handling:
  - SOF on an accepted pixel with counter == 0: normal start.
  - SOF on an accepted pixel with counter != 0: discard the partial frame. That pixel becomes (0,0), the counter becomes 1 (col = 1), and resync_o pulses for one cycle. Stale bits of the discarded frame are overwritten by the new frame.
  - SOF is optional. A pixel without SOF at counter == 0 starts a frame.
- pix_valid_i in FULL is ignored, since ready is low. Upstream must hold the pixel.
- frame_ready_i in LOAD is ignored.
- Reset mid-frame or in FULL: immediate return to the reset values; no partial output.
- Threshold boundaries: pixel == THRESH -> 1; pixel == THRESH-1 -> 0; 0x00 -> 0; 0xFF -> 1.

Decomposition:
- Shared package bnn_pkg holds:
  - IMG_H, IMG_W, PIX_W constants
  - typedef image_t = logic [0:0][IMG_H-1:0][IMG_W-1:0], shared with the BNN top and bench
  - typedef loader_state_e {LOAD, FULL}
- No sub-module. Threshold compare and counters are inline; total is about 150 lines.

Test Plan:
- Stream the bench "7" digit (pixels 0xFF for 1, 0x00 for 0, 784 beats, SOF on first) with frame_ready_i = 0 -> frame_valid_o rises the cycle after beat 784. image_o equals the 28-row constant exactly (row 8 from top = 28'b0000001111111111111110000000), pix_ready_o = 0, and image_o is held stable for 20 cycles.
- From the previous state, pulse frame_ready_i for one cycle -> next cycle frame_valid_o = 0 and pix_ready_o = 1. A second frame of all 0x80 yields image_o all ones.
- Threshold boundary: a frame alternating 0x7F/0x80 -> each row equals 28'h5555555 (0x7F -> 0, 0x80 -> 1, leftmost pixel in the MSB).
- Early SOF: 300 pixels of 0xFF, then SOF plus a full 784-pixel frame of 0x00 -> resync_o pulses once for one cycle, and image_o is all zeros at frame_valid_o. No frame is emitted after the first 300 pixels.
- Random pix_valid_i gaps (50%) and backpressure on frame_ready_i over 3 frames -> every frame matches the reference model bit-for-bit and no pixel is accepted while frame_valid_o = 1.
- Assert rst_i at pixel 500 and again during FULL -> next cycle image_o = 0, frame_valid_o = 0, and pix_ready_o = 1. A subsequent full frame loads correctly from (0,0).
